// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared FSM state encoding, access-length constants and helpers
//          for the memory access unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    function automatic logic len_legal(input logic [2:0] len);
        return (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_extend.sv
// ============================================================================
// Module : mem_load_extend
// Brief  : Sign/zero extension of assembled load data by access length.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_buf,
    input  logic [2:0]      i_len,
    input  logic            i_signed,
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        o_data = i_buf;
        case (i_len)
            LEN_B:   o_data = {{(XLEN-8){i_signed & i_buf[7]}}, i_buf[7:0]};
            LEN_H:   o_data = {{(XLEN-16){i_signed & i_buf[15]}}, i_buf[15:0]};
            default: o_data = i_buf;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Pipeline MEM stage; splits 1/2/4-byte loads/stores into RAM_DW
//          beats, assembles/extends load data and stalls until complete.
//          Optional MEM_MISALIGN_TRAP_EN adds misalign_o and suppresses
//          misaligned accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_DW = 8,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    output logic              stall_mem,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   data,
    input  logic [2:0]        length,
    input  logic              signed_,
    input  logic              write_i,
    input  logic [REG_AW-1:0] regw_addr_i,
    input  logic [XLEN-1:0]   regw_data_i,
    output logic              write_o,
    output logic [REG_AW-1:0] regw_addr_o,
    output logic [XLEN-1:0]   regw_data_o,
    output logic              ram_req,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_wdata,
    output logic [2:0]        ram_length,
    input  logic [RAM_DW-1:0] ram_rdata,
    input  logic              ram_busy,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    input  logic              ram_ready
);

    localparam int         BPB     = RAM_DW / 8;
    localparam int         BPB_SH  = $clog2(BPB);
    localparam int         LANE_SH = $clog2(RAM_DW);
    localparam logic [2:0] BPB_L   = 3'(BPB);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_data;
    logic [XLEN-1:0]     r_buf;
    logic [2:0]          r_len;
    logic [2:0]          r_beat;
    logic                r_signed;
    logic                r_is_load;
    logic [REG_AW-1:0]   r_rd;

    logic                w_mem;
    logic                w_legal;
    logic                w_mis;
    logic                w_start;
    logic [2:0]          w_last_beat;
    logic [7:0]          w_lane_sh;
    logic [XLEN-1:0]     w_ext;

    assign w_mem   = load | store;
    assign w_legal = len_legal(length);
    assign w_start = w_mem & w_legal & ~w_mis;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        case (length)
            LEN_H:   w_mis = addr[0];
            LEN_W:   w_mis = |addr[1:0];
            default: w_mis = 1'b0;
        endcase
    end
`else
    assign w_mis = 1'b0;
`endif

    // Beat index k selects byte offset k*BPB and bit lane k*RAM_DW.
    assign w_lane_sh   = 8'(r_beat) << LANE_SH;
    assign w_last_beat = (r_len > BPB_L) ? (r_len >> BPB_SH) - 3'd1 : 3'd0;
    assign ram_addr    = r_addr + (ADDR_W'(r_beat) << BPB_SH);
    assign ram_wdata   = RAM_DW'(r_data >> w_lane_sh);
    assign ram_length  = (r_len < BPB_L) ? r_len : BPB_L;

    mem_load_extend #(
        .XLEN (XLEN)
    ) u_ext (
        .i_buf    (r_buf),
        .i_len    (r_len),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_buf     <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_signed  <= 1'b0;
            r_is_load <= 1'b0;
            r_rd      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_start) begin
                r_addr    <= addr;
                r_data    <= data;
                r_len     <= length;
                r_signed  <= signed_;
                r_is_load <= load;
                r_rd      <= regw_addr_i;
                r_beat    <= '0;
                r_buf     <= '0;
            end
            if (r_state == ST_WAIT && ram_ready) begin
                if (r_is_load)
                    r_buf <= r_buf | (XLEN'(ram_rdata) << w_lane_sh);
                if (r_beat != w_last_beat)
                    r_beat <= r_beat + 3'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        stall_mem   = 1'b0;
        write_o     = 1'b0;
        regw_addr_o = '0;
        regw_data_o = '0;
        ram_req     = 1'b0;
        ram_write   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_o  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next    = ST_ISSUE;
                    stall_mem = 1'b1;
                end
                if (!w_mem) begin
                    write_o     = write_i;
                    regw_addr_o = regw_addr_i;
                    regw_data_o = regw_data_i;
                end
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_o = w_mem & w_legal & w_mis;
`endif
            end
            ST_ISSUE: begin
                ram_req   = 1'b1;
                ram_write = ~r_is_load;
                stall_mem = 1'b1;
                if (!ram_busy)
                    w_next = ST_WAIT;
            end
            ST_WAIT: begin
                stall_mem = 1'b1;
                if (ram_ready)
                    w_next = (r_beat == w_last_beat) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
                if (r_is_load) begin
                    write_o     = 1'b1;
                    regw_addr_o = r_rd;
                    regw_data_o = w_ext;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Outputs are forced quiet for as long as reset is held.
        if (!reset) begin
            stall_mem   = 1'b0;
            write_o     = 1'b0;
            regw_addr_o = '0;
            regw_data_o = '0;
            ram_req     = 1'b0;
            ram_write   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o  = 1'b0;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed table-driven bench for mem_access_unit (RAM_DW=8 and a
//          RAM_DW=32 instance for the busy/single-beat case).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_mem, load, store, signed_, write_i;
    logic [31:0] addr, data, regw_data_i, regw_data_o;
    logic [2:0]  length, ram_length;
    logic [4:0]  regw_addr_i, regw_addr_o;
    logic        write_o, ram_req, ram_write;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        ram_busy  = 1'b0;
    logic        ram_ready = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o, b_mis;
`endif

    logic        b_stall, b_load, b_write_o, b_ram_req, b_ram_write;
    logic [31:0] b_addr, b_regw_data_o, b_ram_addr, b_ram_wdata;
    logic [2:0]  b_len, b_ram_length;
    logic [4:0]  b_regw_addr_o;
    logic [31:0] b_ram_rdata = 32'h0;
    logic        b_ram_busy  = 1'b0;
    logic        b_ram_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .RAM_DW(8), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .stall_mem(stall_mem), .load(load), .store(store),
        .addr(addr), .data(data), .length(length), .signed_(signed_),
        .write_i(write_i), .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
        .write_o(write_o), .regw_addr_o(regw_addr_o), .regw_data_o(regw_data_o),
        .ram_req(ram_req), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_length(ram_length), .ram_rdata(ram_rdata),
        .ram_busy(ram_busy),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .ram_ready(ram_ready)
    );

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .RAM_DW(32), .REG_AW(5)) dut_b (
        .clk(clk), .reset(reset), .stall_mem(b_stall), .load(b_load), .store(1'b0),
        .addr(b_addr), .data(32'h0), .length(b_len), .signed_(1'b0),
        .write_i(1'b0), .regw_addr_i(5'd7), .regw_data_i(32'h0),
        .write_o(b_write_o), .regw_addr_o(b_regw_addr_o), .regw_data_o(b_regw_data_o),
        .ram_req(b_ram_req), .ram_write(b_ram_write), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_length(b_ram_length), .ram_rdata(b_ram_rdata),
        .ram_busy(b_ram_busy),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(b_mis),
`endif
        .ram_ready(b_ram_ready)
    );

    // ---------------- RAM model for the 8-bit instance ----------------
    logic [7:0]  wmem [int];
    logic [31:0] logA_addr [128];
    logic        logA_wr   [128];
    logic [7:0]  logA_wd   [128];
    logic [2:0]  logA_len  [128];
    int          nA = 0;
    int          latA = 1;
    int          cntA = 0;
    bit          pendA = 0;
    int          pA = 0;

    function automatic logic [7:0] ram_init(input int a);
        case (a)
            'h1000: return 8'h78;
            'h1001: return 8'h56;
            'h1002: return 8'h34;
            'h1003: return 8'h12;
            'h2003: return 8'h80;
            'h3000: return 8'h34;
            'h3001: return 8'h81;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            pendA     = 0;
            ram_ready = 1'b0;
            ram_busy  = 1'b0;
        end else begin
            ram_ready = 1'b0;
            if (pendA) begin
                cntA--;
                if (cntA == 0) begin
                    ram_ready = 1'b1;
                    ram_rdata = wmem.exists(pA) ? wmem[pA] : ram_init(pA);
                    pendA     = 0;
                end
            end else if (ram_req) begin
                if (nA < 128) begin
                    logA_addr[nA] = ram_addr;
                    logA_wr[nA]   = ram_write;
                    logA_wd[nA]   = ram_wdata;
                    logA_len[nA]  = ram_length;
                    nA++;
                end
                pA = int'(ram_addr[15:0]);
                if (ram_write) wmem[pA] = ram_wdata;
                pendA = 1;
                cntA  = latA;
            end
        end
    end

    // ---------------- RAM model for the 32-bit instance ----------------
    int nB = 0;
    int nbusyB = 0;
    int busyB_target = 0;
    bit pendB = 0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            pendB       = 0;
            b_ram_ready = 1'b0;
            b_ram_busy  = 1'b0;
        end else begin
            b_ram_ready = 1'b0;
            if (pendB) begin
                pendB       = 0;
                b_ram_ready = 1'b1;
                b_ram_rdata = 32'hCAFEF00D;
            end else if (b_ram_req) begin
                if (nbusyB < busyB_target) begin
                    b_ram_busy = 1'b1;
                    nbusyB++;
                end else begin
                    b_ram_busy = 1'b0;
                    nB++;
                    pendB = 1;
                end
            end else begin
                b_ram_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
        logic        sgn;
        logic        wi;
        logic [4:0]  rd;
        logic [31:0] wd;
        int          lat;
        logic        e_write;
        logic [31:0] e_data;
        int          e_beats;
        logic        e_mis;
    } vec_t;

    vec_t vecs[13];

    task automatic clear_inputs();
        load = 1'b0; store = 1'b0; write_i = 1'b0;
        addr = '0; data = '0; length = 3'd0; signed_ = 1'b0;
        regw_addr_i = '0; regw_data_i = '0;
    endtask

    // Call at a negedge with the unit idle.
    task automatic run_vec(input vec_t v, input int idx);
        int  base, cyc;
        bit  done;
        logic [31:0] ew;
        base = nA;
        latA = v.lat;
        load = v.ld; store = v.st; addr = v.addr; data = v.data; length = v.len;
        signed_ = v.sgn; write_i = v.wi; regw_addr_i = v.rd; regw_data_i = v.wd;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        chk($sformatf("v%0d_misalign", idx), {31'b0, misalign_o}, {31'b0, v.e_mis});
`endif
        if (v.e_beats == 0) begin
            chk($sformatf("v%0d_stall", idx), {31'b0, stall_mem}, 32'd0);
            chk($sformatf("v%0d_write_o", idx), {31'b0, write_o}, {31'b0, v.e_write});
            if (v.e_write) begin
                chk($sformatf("v%0d_rd", idx), {27'b0, regw_addr_o}, {27'b0, v.rd});
                chk($sformatf("v%0d_data", idx), regw_data_o, v.e_data);
            end
            @(negedge clk);
            clear_inputs();
            chk($sformatf("v%0d_beats", idx), nA - base, 32'd0);
        end else begin
            chk($sformatf("v%0d_stall_start", idx), {31'b0, stall_mem}, 32'd1);
            cyc = 1;
            done = 0;
            while (!done && cyc < 200) begin
                @(negedge clk);
                if (stall_mem) cyc++;
                else done = 1;
            end
            chk($sformatf("v%0d_timeout", idx), {31'b0, stall_mem}, 32'd0);
            chk($sformatf("v%0d_cycles", idx), cyc, 1 + v.e_beats * (1 + v.lat));
            chk($sformatf("v%0d_write_o", idx), {31'b0, write_o}, {31'b0, v.e_write});
            if (v.e_write) begin
                chk($sformatf("v%0d_rd", idx), {27'b0, regw_addr_o}, {27'b0, v.rd});
                chk($sformatf("v%0d_data", idx), regw_data_o, v.e_data);
            end
            clear_inputs();
            chk($sformatf("v%0d_beats", idx), nA - base, v.e_beats);
            for (int k = 0; k < v.e_beats && base + k < nA; k++) begin
                chk($sformatf("v%0d_b%0d_addr", idx, k), logA_addr[base+k], v.addr + k);
                chk($sformatf("v%0d_b%0d_wr", idx, k), {31'b0, logA_wr[base+k]},
                    {31'b0, v.st & ~v.ld});
                chk($sformatf("v%0d_b%0d_len", idx, k), {29'b0, logA_len[base+k]}, 32'd1);
                if (v.st && !v.ld) begin
                    ew = (v.data >> (8 * k)) & 32'hFF;
                    chk($sformatf("v%0d_b%0d_wdata", idx, k), {24'b0, logA_wd[base+k]}, ew);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, req_cyc, bad, base;
        bit done;

        //         ld    st    addr          data          len   sgn   wi    rd     wd     lat wr   e_data        bts mis
        vecs[0]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        3'd4, 1'b0, 1'b0, 5'd3,  32'h0,  2, 1'b1, 32'h12345678, 4, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h2003, 32'h0,        3'd1, 1'b1, 1'b0, 5'd4,  32'h0,  1, 1'b1, 32'hFFFFFF80, 1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h2003, 32'h0,        3'd1, 1'b0, 1'b0, 5'd4,  32'h0,  1, 1'b1, 32'h00000080, 1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h3000, 32'h0,        3'd2, 1'b1, 1'b0, 5'd6,  32'h0,  1, 1'b1, 32'hFFFF8134, 2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h3000, 32'h0,        3'd2, 1'b0, 1'b0, 5'd6,  32'h0,  3, 1'b1, 32'h00008134, 2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0010, 32'h0000ABCD, 3'd2, 1'b0, 1'b0, 5'd0,  32'h0,  2, 1'b0, 32'h0,        2, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0020, 32'hDEADBEEF, 3'd4, 1'b0, 1'b0, 5'd0,  32'h0,  1, 1'b0, 32'h0,        4, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0020, 32'h0,        3'd4, 1'b0, 1'b0, 5'd9,  32'h0,  1, 1'b1, 32'hDEADBEEF, 4, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 1'b1, 5'd5,  32'h55, 1, 1'b1, 32'h00000055, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        3'd3, 1'b0, 1'b1, 5'd8,  32'h77, 1, 1'b0, 32'h0,        0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h2003, 32'h11,       3'd1, 1'b1, 1'b0, 5'd10, 32'h0,  1, 1'b1, 32'hFFFFFF80, 1, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[11] = '{1'b1, 1'b0, 32'h1002, 32'h0,        3'd4, 1'b0, 1'b0, 5'd11, 32'h0,  1, 1'b0, 32'h0,        0, 1'b1};
`else
        vecs[11] = '{1'b1, 1'b0, 32'h1002, 32'h0,        3'd4, 1'b0, 1'b0, 5'd11, 32'h0,  1, 1'b1, 32'h00001234, 4, 1'b0};
`endif
        vecs[12] = '{1'b1, 1'b0, 32'h1001, 32'h0,        3'd1, 1'b0, 1'b0, 5'd12, 32'h0,  1, 1'b1, 32'h00000056, 1, 1'b0};

        // Reset held with a pending load and an upstream write: all quiet.
        reset = 1'b0;
        b_load = 1'b0; b_addr = '0; b_len = 3'd0;
        load = 1'b1; store = 1'b0; addr = 32'h1000; data = '0; length = 3'd4;
        signed_ = 1'b0; write_i = 1'b1; regw_addr_i = 5'd5; regw_data_i = 32'h55;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall_mem}, 32'd0);
        chk("rst_req", {31'b0, ram_req}, 32'd0);
        chk("rst_ram_write", {31'b0, ram_write}, 32'd0);
        chk("rst_write_o", {31'b0, write_o}, 32'd0);
        chk("rst_regw_addr", {27'b0, regw_addr_o}, 32'd0);
        chk("rst_regw_data", regw_data_o, 32'd0);
        clear_inputs();
        #2 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
            @(negedge clk);
        end

        // Asynchronous reset during the WAIT of the second beat.
        latA = 2;
        load = 1'b1; addr = 32'h1000; length = 3'd4;
        base = nA;
        cyc = 0;
        while ((nA - base) < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_reach_beat2", nA - base, 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_stall_before", {31'b0, stall_mem}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_stall_async", {31'b0, stall_mem}, 32'd0);
        chk("rstmid_req_async", {31'b0, ram_req}, 32'd0);
        load = 1'b0; length = 3'd0; addr = '0;
        reset = 1'b1;
        #1;
        chk("rstmid_idle_after", {31'b0, stall_mem}, 32'd0);
        chk("rstmid_no_wb", {31'b0, write_o}, 32'd0);
        @(negedge clk);
        run_vec(vecs[0], 100);
        @(negedge clk);

        // 32-bit port: single beat held through three busy cycles.
        busyB_target = nbusyB + 3;
        base = nB;
        b_load = 1'b1; b_addr = 32'h40; b_len = 3'd4;
        req_cyc = 0; bad = 0; cyc = 0; done = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (b_ram_req) begin
                req_cyc++;
                if (b_ram_addr !== 32'h40 || b_ram_length !== 3'd4 ||
                    b_ram_write !== 1'b0 || b_ram_wdata !== 32'h0)
                    bad++;
            end
            if (!b_stall) done = 1;
        end
        chk("busy_timeout", {31'b0, b_stall}, 32'd0);
        chk("busy_req_cycles", req_cyc, 32'd4);
        chk("busy_req_stable", bad, 32'd0);
        chk("busy_beats", nB - base, 32'd1);
        chk("busy_write_o", {31'b0, b_write_o}, 32'd1);
        chk("busy_rd", {27'b0, b_regw_addr_o}, 32'd7);
        chk("busy_data", b_regw_data_o, 32'hCAFEF00D);
        b_load = 1'b0;
        @(negedge clk);
        chk("busy_back_idle", {31'b0, b_stall}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
